// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and record layouts for the instruction fetch buffer
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = '0;

  // Metadata recorded per in-flight imem request; epoch tags it against redirects.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic                  predTaken;
    logic                  epoch;
  } fetch_meta_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic                  predTaken;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, used for in-flight metadata and the decode buffer
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_idx;
  logic [AW-1:0]    r_rd_idx;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
    return (idx == AW'(DEPTH - 1)) ? '0 : idx + AW'(1);
  endfunction

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_idx];

  // A pop frees the slot the same cycle, so a full FIFO can still accept a push alongside it.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_idx <= next_idx(r_wr_idx);
      if (w_do_pop)  r_rd_idx <= next_idx(r_rd_idx);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_idx] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - instruction fetch with in-flight tracking, epoch squash and decode buffer
// Define FETCH_PERF_EN to add the perfFetched/perfDropped/perfStall counters.
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = FETCH_XLEN,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(FETCH_RESET_PC)
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectPc,
  input  logic            usePredictor,
  input  logic            bPredictTaken,
  input  logic [XLEN-1:0] btbTarget,
  output logic            imemReqValid,
  input  logic            imemReqReady,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemRespValid,
  input  logic [31:0]     imemRespData,
  output logic            decValid,
  input  logic            decReady,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic            bPredictedTaken
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perfFetched,
  output logic [31:0]     perfDropped,
  output logic [31:0]     perfStall
`endif
);

  localparam int unsigned META_W  = XLEN + 2;
  localparam int unsigned ENTRY_W = XLEN + 33;
  localparam int unsigned OCW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BCW     = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    r_fetch_pc;
  logic [XLEN-1:0]    w_next_pc;
  logic               r_epoch;
  logic               w_pred_taken;
  logic               w_room;
  logic               w_req_fire;
  logic               w_resp;
  logic               w_keep;
  logic [META_W-1:0]  w_meta_in;
  logic [META_W-1:0]  w_meta_out;
  logic [ENTRY_W-1:0] w_entry_in;
  logic [ENTRY_W-1:0] w_entry_out;
  logic               w_if_full;
  logic               w_if_empty;
  logic               w_buf_full;
  logic               w_buf_empty;
  logic [OCW-1:0]     w_outstanding;
  logic [BCW-1:0]     w_occupancy;
  logic               w_unused;

  assign w_pred_taken = usePredictor && bPredictTaken;

  // Every outstanding request has a reserved buffer slot, so a returning response always fits.
  assign w_room       = (32'(w_outstanding) + 32'(w_occupancy)) < 32'(DEPTH);
  assign imemReqValid = rstN && !redirectValid && !w_if_full && w_room;
  assign imemAddr     = r_fetch_pc;
  assign w_req_fire   = imemReqValid && imemReqReady;

  // Responses with nothing outstanding (e.g. leftovers from before a reset) are ignored.
  assign w_resp = imemRespValid && !w_if_empty;
  assign w_keep = w_resp && !redirectValid && (w_meta_out[0] == r_epoch);

  assign w_meta_in  = {r_fetch_pc, w_pred_taken, r_epoch};
  assign w_entry_in = {w_meta_out[META_W-1:2], imemRespData, w_meta_out[1]};

  always_comb begin
    w_next_pc = r_fetch_pc;
    if (redirectValid) begin
      w_next_pc = redirectPc;
    end else if (w_req_fire) begin
      w_next_pc = w_pred_taken ? btbTarget : r_fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_fetch_pc <= RESET_PC;
      r_epoch    <= 1'b0;
    end else begin
      r_fetch_pc <= w_next_pc;
      if (redirectValid) r_epoch <= ~r_epoch;
    end
  end

  fetch_fifo #(
    .WIDTH (int'(META_W)),
    .DEPTH (int'(MAX_OUTSTANDING))
  ) u_inflight (
    .clk       (clk),
    .rstN      (rstN),
    .push      (w_req_fire),
    .push_data (w_meta_in),
    .pop       (w_resp),
    .pop_data  (w_meta_out),
    .flush     (1'b0),
    .full      (w_if_full),
    .empty     (w_if_empty),
    .count     (w_outstanding)
  );

  fetch_fifo #(
    .WIDTH (int'(ENTRY_W)),
    .DEPTH (int'(DEPTH))
  ) u_buffer (
    .clk       (clk),
    .rstN      (rstN),
    .push      (w_keep),
    .push_data (w_entry_in),
    .pop       (decValid && decReady),
    .pop_data  (w_entry_out),
    .flush     (redirectValid),
    .full      (w_buf_full),
    .empty     (w_buf_empty),
    .count     (w_occupancy)
  );

  // Decode outputs are forced to zero while empty so stale storage never leaks out.
  assign decValid        = !w_buf_empty;
  assign pc              = w_buf_empty ? '0 : w_entry_out[ENTRY_W-1:33];
  assign instr           = w_buf_empty ? '0 : w_entry_out[32:1];
  assign bPredictedTaken = !w_buf_empty && w_entry_out[0];
  assign pcPlus4         = w_buf_empty ? '0 : pc + XLEN'(4);

  assign w_unused = w_buf_full;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (decValid && decReady) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_resp && !w_keep)    r_perf_dropped <= r_perf_dropped + 32'd1;
      if (!imemReqValid)        r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perfFetched = r_perf_fetched;
  assign perfDropped = r_perf_dropped;
  assign perfStall   = r_perf_stall;
`endif

endmodule
